// File: rtl/ctrl_pkg.sv
// Shared control types for the I2S receiver: operating-point struct, FSM states
// and the supported word widths.
package ctrl_pkg;

    typedef enum logic {
        f16bits = 1'b0,
        f32bits = 1'b1
    } frame_size_t;

    typedef struct packed {
        frame_size_t frame_size;
    } OP_t;

    typedef enum logic [1:0] {
        SYNC,
        WAIT_L,
        RX_L,
        RX_R
    } rx_state_t;

    localparam int W16 = 16;
    localparam int W32 = 32;

    function automatic logic [5:0] frame_width(input frame_size_t fs);
        return (fs == f16bits) ? 6'(W16) : 6'(W32);
    endfunction

endpackage

// File: rtl/i2s_word_shifter.sv
// Serial-to-parallel word assembler shared by both I2S channels; detects ws
// transitions and presents the completed word combinationally at the word-end edge.
module i2s_word_shifter
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        en,
    input  logic        ws,
    input  logic        sd,
    input  logic [5:0]  w,
    output logic        ws_edge,
    output logic [31:0] word
);

    logic        ws_q, ws_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  idx;

    function automatic logic [5:0] sat_inc(input logic [5:0] c);
        return (c >= 6'd32) ? 6'd32 : c + 6'd1;
    endfunction

    always_comb begin
        ws_d    = ws;
        ws_edge = (ws != ws_q);
        idx     = 5'(w - 6'd1 - cnt_q);
        // The bit at a ws transition still belongs to the ending word.
        word    = sr_q;
        if (cnt_q < w) begin
            word[idx] = sd;
        end
        if (!en || ws_edge) begin
            sr_d  = '0;
            cnt_d = '0;
        end else begin
            sr_d  = word;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ws_q  <= 1'b0;
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            ws_q  <= ws_d;
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: frame-alignment FSM, left-word holding register and a
// valid/ready output stage with sticky overrun reporting.
module i2s_rx
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_,
    input  logic        en,
    input  OP_t         OP,
    input  logic        ws,
    input  logic        sd,
    output logic [31:0] rx_data_l,
    output logic [31:0] rx_data_r,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        ovr,
    input  logic        ovr_clr
);

    rx_state_t   state_q, state_d;
    logic [5:0]  w_q, w_d;
    logic [31:0] hold_l_q, hold_l_d;
    logic [31:0] data_l_q, data_l_d;
    logic [31:0] data_r_q, data_r_d;
    logic        valid_q, valid_d;
    logic        ovr_q, ovr_d;
    logic        ws_edge;
    logic [31:0] word;
    logic        publish, accept, overrun;

    i2s_word_shifter u_shifter (
        .clk     (clk),
        .rst_    (rst_),
        .en      (en),
        .ws      (ws),
        .sd      (sd),
        .w       (w_q),
        .ws_edge (ws_edge),
        .word    (word)
    );

    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        hold_l_d = hold_l_q;
        data_l_d = data_l_q;
        data_r_d = data_r_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        publish  = 1'b0;
        overrun  = 1'b0;
        accept   = valid_q && rx_ready;

        if (!en) begin
            state_d = SYNC;
        end else if (ws_edge) begin
            case (state_q)
                SYNC: begin
                    state_d = ws ? WAIT_L : RX_L;
                    w_d     = frame_width(OP.frame_size);
                end
                WAIT_L: if (!ws) state_d = RX_L;
                RX_L: begin
                    state_d  = RX_R;
                    hold_l_d = word;
                end
                RX_R: begin
                    state_d = RX_L;
                    publish = 1'b1;
                end
                default: state_d = SYNC;
            endcase
        end

        // A pending pair that is not being accepted wins over a new one.
        if (publish) begin
            if (valid_q && !rx_ready) begin
                overrun = 1'b1;
            end else begin
                data_l_d = hold_l_q;
                data_r_d = word;
                valid_d  = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end

        if (ovr_clr) ovr_d = 1'b0;
        if (overrun) ovr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= SYNC;
            w_q      <= 6'(W32);
            hold_l_q <= '0;
            data_l_q <= '0;
            data_r_q <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            hold_l_q <= hold_l_d;
            data_l_q <= data_l_d;
            data_r_q <= data_r_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rx_data_l = data_l_q;
    assign rx_data_r = data_r_q;
    assign rx_valid  = valid_q;
    assign ovr       = ovr_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: builds I2S bit streams from whole samples and compares the
// outputs against a sample-level model of framing, truncation and handshake.
module tb_i2s_rx;
    import ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic        en = 1'b0;
    OP_t         op;
    logic        ws = 1'b0;
    logic        sd = 1'b0;
    logic [31:0] rx_data_l, rx_data_r;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        ovr;
    logic        ovr_clr = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cur_w = 16;
    int          vld_cnt = 0;
    bit          clr_req = 0;
    bit          clr_on_pub = 0;
    logic [31:0] exp_l = '0, exp_r = '0;
    logic        exp_valid = 1'b0, exp_ovr = 1'b0;

    i2s_rx dut (
        .clk       (clk),
        .rst_      (rst_),
        .en        (en),
        .OP        (op),
        .ws        (ws),
        .sd        (sd),
        .rx_data_l (rx_data_l),
        .rx_data_r (rx_data_r),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .ovr       (ovr),
        .ovr_clr   (ovr_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample as the receiver should see it: first W bits sent, MSB first,
    // zero-filled when short, right-aligned.
    function automatic logic [31:0] exp_word(input logic [31:0] d, input int n, input int w);
        logic [63:0] v;
        v = {32'd0, d} & ((64'd1 << n) - 64'd1);
        if (n >= w) v = v >> (n - w);
        else        v = v << (w - n);
        v = v & ((64'd1 << w) - 64'd1);
        return v[31:0];
    endfunction

    task automatic sck_step(input logic w, input logic d, input bit pub,
                            input logic [31:0] el, input logic [31:0] er);
        bit ovf;
        ws      = w;
        sd      = d;
        ovr_clr = clr_req | (pub & clr_on_pub);
        @(posedge clk);
        ovf = 0;
        if (pub) begin
            if (exp_valid && !rx_ready) ovf = 1;
            else begin
                exp_l     = el;
                exp_r     = er;
                exp_valid = 1'b1;
            end
        end else if (exp_valid && rx_ready) begin
            exp_valid = 1'b0;
        end
        if (ovr_clr) exp_ovr = 1'b0;
        if (ovf)     exp_ovr = 1'b1;
        #1;
        if (rx_valid) vld_cnt++;
        check("rx_valid", {31'd0, rx_valid}, {31'd0, exp_valid});
        check("ovr", {31'd0, ovr}, {31'd0, exp_ovr});
        check("rx_data_l", rx_data_l, exp_l);
        check("rx_data_r", rx_data_r, exp_r);
        clr_req = 0;
        ovr_clr = 1'b0;
    endtask

    // ws leads the data by one bit: it flips on the edge carrying the LSB.
    task automatic send_word(input logic ch, input logic [31:0] data, input int n,
                             input bit pub, input logic [31:0] el, input logic [31:0] er);
        for (int k = 0; k < n; k++)
            sck_step((k == n - 1) ? ~ch : ch, data[n-1-k], pub && (k == n - 1), el, er);
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r, input int nl, input int nr);
        logic [31:0] el, er;
        el = exp_word(l, nl, cur_w);
        er = exp_word(r, nr, cur_w);
        send_word(1'b0, l, nl, 1'b0, '0, '0);
        send_word(1'b1, r, nr, 1'b1, el, er);
    endtask

    task automatic idle(input int n, input frame_size_t fs);
        en            = 1'b0;
        op.frame_size = fs;
        cur_w         = (fs == f16bits) ? 16 : 32;
        for (int k = 0; k < n; k++) sck_step(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        en = 1'b1;
    endtask

    task automatic preamble(input int n);
        send_word(1'b1, $urandom, n, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] a, b, c, d;
        int nl, nr;
        op.frame_size = f16bits;

        repeat (2) @(posedge clk);
        #1;
        check("reset_l", rx_data_l, 32'h0);
        check("reset_r", rx_data_r, 32'h0);
        check("reset_valid", {31'd0, rx_valid}, 32'h0);
        check("reset_ovr", {31'd0, ovr}, 32'h0);
        rst_ = 1'b1;

        // 16-bit pair after starting in the middle of a right word
        idle(2, f16bits);
        preamble(4);
        check("no_pub_after_partial", {31'd0, rx_valid}, 32'h0);
        send_pair(32'hA5C3, 32'h0F0F, 16, 16);
        check("l16", rx_data_l, 32'h0000A5C3);
        check("r16", rx_data_r, 32'h00000F0F);
        check("valid16", {31'd0, rx_valid}, 32'h1);

        // 32-bit streaming with the consumer always ready
        rx_ready = 1'b1;
        idle(2, f32bits);
        preamble(3);
        vld_cnt = 0;
        send_pair(32'hDEADBEEF, 32'h12345678, 32, 32);
        check("l32", rx_data_l, 32'hDEADBEEF);
        check("r32", rx_data_r, 32'h12345678);
        send_pair($urandom, $urandom, 32, 32);
        check("one_pair_per_64", vld_cnt, 32'd2);
        check("no_ovr_streaming", {31'd0, ovr}, 32'h0);

        // short left word is zero-filled
        send_pair(32'h00ABCDEF, $urandom, 24, 32);
        check("l24_zero_fill", rx_data_l, 32'hABCDEF00);

        // overrun: second pair dropped while the first is held
        idle(2, f32bits);
        rx_ready = 1'b0;
        preamble(5);
        a = $urandom; b = $urandom; c = $urandom; d = $urandom;
        send_pair(a, b, 32, 32);
        send_pair(c, d, 32, 32);
        check("held_l", rx_data_l, a);
        check("held_r", rx_data_r, b);
        check("ovr_set", {31'd0, ovr}, 32'h1);
        clr_req = 1;
        idle(1, f32bits);
        check("ovr_cleared", {31'd0, ovr}, 32'h0);
        idle(1, f32bits);
        preamble(3);
        clr_on_pub = 1;
        send_pair(c, d, 32, 32);
        clr_on_pub = 0;
        check("ovr_set_wins_clr", {31'd0, ovr}, 32'h1);
        check("held_l_again", rx_data_l, a);

        // asynchronous reset in the middle of a left word, then resync
        rx_ready = 1'b1;
        idle(2, f16bits);
        preamble(4);
        for (int k = 0; k < 7; k++) sck_step(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, '0);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst_l", rx_data_l, 32'h0);
        check("async_rst_r", rx_data_r, 32'h0);
        check("async_rst_valid", {31'd0, rx_valid}, 32'h0);
        check("async_rst_ovr", {31'd0, ovr}, 32'h0);
        exp_l = '0; exp_r = '0; exp_valid = 1'b0; exp_ovr = 1'b0;
        @(posedge clk);
        #1 rst_ = 1'b1;
        send_word(1'b0, $urandom, 9, 1'b0, '0, '0);
        send_word(1'b1, $urandom, 16, 1'b0, '0, '0);
        check("no_pub_partial_pair", {31'd0, rx_valid}, 32'h0);
        a = $urandom & 32'hFFFF; b = $urandom & 32'hFFFF;
        send_pair(a, b, 16, 16);
        check("resync_l", rx_data_l, a);
        check("resync_r", rx_data_r, b);

        // randomized frames: mode, word lengths, ready and overrun clears
        for (int it = 0; it < 6; it++) begin
            idle(2, ($urandom_range(0, 1) == 0) ? f16bits : f32bits);
            preamble($urandom_range(2, 8));
            for (int p = 0; p < 3; p++) begin
                rx_ready   = 1'($urandom_range(0, 1));
                clr_on_pub = ($urandom_range(0, 3) == 0);
                nl = $urandom_range(cur_w - 3, (cur_w == 16) ? 20 : 32);
                nr = $urandom_range(cur_w - 3, (cur_w == 16) ? 20 : 32);
                send_pair($urandom, $urandom, nl, nr);
                clr_on_pub = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
